// File: rtl/cond_pkg.sv
// Shared definitions for the condition/flags unit: ARM condition codes,
// NZCV bit positions and the controller state encoding.
package cond_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int N = 3;
  localparam int Z = 2;
  localparam int C = 1;
  localparam int V = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_WB   = 2'b10
  } state_t;

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition evaluator: decides whether an instruction with
// condition field Cond executes under the given NZCV flags.
module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic n, z, c, v;

  assign n = Flags[N];
  assign z = Flags[Z];
  assign c = Flags[C];
  assign v = Flags[V];

  always_comb begin
    CondEx = 1'b0;
    case (Cond)
      COND_EQ: CondEx = z;
      COND_NE: CondEx = ~z;
      COND_CS: CondEx = c;
      COND_CC: CondEx = ~c;
      COND_MI: CondEx = n;
      COND_PL: CondEx = ~n;
      COND_VS: CondEx = v;
      COND_VC: CondEx = ~v;
      COND_HI: CondEx = c & ~z;
      COND_LS: CondEx = ~c | z;
      COND_GE: CondEx = (n == v);
      COND_LT: CondEx = (n != v);
      COND_GT: CondEx = ~z & (n == v);
      COND_LE: CondEx = z | (n != v);
      COND_AL: CondEx = 1'b1;
      COND_NV: CondEx = 1'b0;
      default: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Multicycle condition/flags unit: holds NZCV, evaluates each accepted
// instruction's condition, commits ALU flags and issues one-cycle write strobes.
module cond_unit
  import cond_pkg::*;
#(
  parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ExValid,
  output logic       Ready,
  input  logic [3:0] Cond,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  input  logic [3:0] ALUFlags,
  output logic [3:0] Flags,
  output logic       CondEx,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite
);

  state_t     state, state_next;
  logic [3:0] cond_q;
  logic [1:0] flag_w_q;
  logic       pcs_q, reg_w_q, mem_w_q, no_write_q;
  logic       cond_ex_eval;
  logic       accept;
  logic       commit;

  cond_eval u_cond_eval (
    .Cond   (Cond),
    .Flags  (Flags),
    .CondEx (cond_ex_eval)
  );

  assign accept = ExValid & Ready;
  // The reserved code can never commit, even if CondEx were corrupted.
  assign commit = CondEx & (cond_q != COND_NV);

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (ExValid) state_next = S_EXEC;
        else         state_next = S_IDLE;
      end
      S_EXEC: state_next = S_WB;
      S_WB: begin
        if (ExValid) state_next = S_EXEC;
        else         state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      Ready      <= 1'b1;
      Flags      <= FLAGS_RESET;
      CondEx     <= 1'b0;
      PCSrc      <= 1'b0;
      RegWrite   <= 1'b0;
      MemWrite   <= 1'b0;
      cond_q     <= 4'b0000;
      flag_w_q   <= 2'b00;
      pcs_q      <= 1'b0;
      reg_w_q    <= 1'b0;
      mem_w_q    <= 1'b0;
      no_write_q <= 1'b0;
    end else begin
      state    <= state_next;
      Ready    <= (state_next != S_EXEC);
      PCSrc    <= 1'b0;
      RegWrite <= 1'b0;
      MemWrite <= 1'b0;
      if (accept) begin
        cond_q     <= Cond;
        flag_w_q   <= FlagW;
        pcs_q      <= PCS;
        reg_w_q    <= RegW;
        mem_w_q    <= MemW;
        no_write_q <= NoWrite;
        CondEx     <= cond_ex_eval;
      end
      // Strobes are registered at the end of EXEC so they are high during WB.
      if (state == S_EXEC) begin
        if (commit && flag_w_q[1]) Flags[N:Z] <= ALUFlags[N:Z];
        if (commit && flag_w_q[0]) Flags[C:V] <= ALUFlags[C:V];
        PCSrc    <= pcs_q & commit;
        RegWrite <= reg_w_q & ~no_write_q & commit;
        MemWrite <= mem_w_q & commit;
      end
    end
  end

endmodule
